// File: rtl/core_control_fsm_pkg.sv
// Shared definitions for the RV32I multi-cycle control sequencer:
// state encoding, opcode constants, write-back and next-PC select encodings,
// and the legal-opcode check used at DECODE.
package core_control_fsm_pkg;

  typedef enum logic [2:0] {
    FETCH      = 3'd0,
    FETCH_WAIT = 3'd1,
    DECODE     = 3'd2,
    EXECUTE    = 3'd3,
    MEM        = 3'd4,
    MEM_WAIT   = 3'd5,
    WRITE_BACK = 3'd6,
    TRAP       = 3'd7
  } state_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  typedef enum logic [1:0] {
    WD_ALU = 2'd0,
    WD_MEM = 2'd1,
    WD_PC4 = 2'd2,
    WD_IMM = 2'd3
  } wd_sel_t;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'd0,
    PC_JAL    = 2'd1,
    PC_JALR   = 2'd2,
    PC_BRANCH = 2'd3
  } pc_sel_t;

  // SYSTEM (ecall/ebreak/csr) is deliberately absent: it traps.
  function automatic logic is_legal_opcode(input logic [6:0] op);
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
      OP_LOAD, OP_STORE, OP_IMM, OP_REG, OP_FENCE: return 1'b1;
      default:                                      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/core_control_fsm_if.sv
// Control bundle between the sequencer and the datapath.
// Datapath -> sequencer: run, opcode, funct3, branch_taken.
// Sequencer -> datapath: fetch/IR strobes, RF read/write, ALU latch,
// data-memory strobes and size, write-back/next-PC selects, illegal flag,
// retired-instruction count.
interface core_control_fsm_if #(
  parameter int unsigned RETIRE_W = 32
);
  logic                run;
  logic [6:0]          opcode;
  logic [2:0]          funct3;
  logic                branch_taken;
  logic                imem_en;
  logic                ir_load;
  logic                rf_rd_en;
  logic                alu_en;
  logic                dmem_addr_load;
  logic                dmem_wren;
  logic [2:0]          dmem_funct3;
  logic                rf_wren;
  logic [1:0]          rf_wd_sel;
  logic                pc_load;
  logic [1:0]          pc_sel;
  logic                illegal_instr;
  logic [RETIRE_W-1:0] retired_count;

  modport master (
    input  run, opcode, funct3, branch_taken,
    output imem_en, ir_load, rf_rd_en, alu_en, dmem_addr_load, dmem_wren,
           dmem_funct3, rf_wren, rf_wd_sel, pc_load, pc_sel, illegal_instr,
           retired_count
  );

  modport slave (
    output run, opcode, funct3, branch_taken,
    input  imem_en, ir_load, rf_rd_en, alu_en, dmem_addr_load, dmem_wren,
           dmem_funct3, rf_wren, rf_wd_sel, pc_load, pc_sel, illegal_instr,
           retired_count
  );
endinterface

// File: rtl/core_control_fsm_mem_wait_counter.sv
// Loadable down-counter shared by the instruction-fetch and data-load waits.
// Ports: clk, reset (async, active-high), load/load_val (preset),
// done (count has reached zero). Counts down to zero and stays there.
module mem_wait_counter #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             done
);
  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)            cnt <= '0;
    else if (load)        cnt <= load_val;
    else if (cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign done = (cnt == '0);
endmodule

// File: rtl/core_control_fsm.sv
// Multi-cycle RV32I control sequencer: FETCH, FETCH_WAIT, DECODE, EXECUTE,
// MEM, MEM_WAIT, WRITE_BACK, plus a TRAP state left only through reset.
// Ports: clk, reset (async, active-high), bus (control bundle, master side).
// MEM_LATENCY (1..4) sets the length of both wait states.
// Strobes are decoded from the current state and the latched opcode/funct3/
// branch result; all of them are 0 while reset is high.
module core_control_fsm
  import core_control_fsm_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned RETIRE_W    = 32
) (
  input  logic               clk,
  input  logic               reset,
  core_control_fsm_if.master bus
);
  localparam int unsigned     CNT_W     = 2;
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(MEM_LATENCY - 1);

  state_t              state;
  logic [6:0]          op_q;
  logic [2:0]          f3_q;
  logic                taken_q;
  logic                illegal_q;
  logic [RETIRE_W-1:0] retired_q;
  logic                cnt_load;
  logic                cnt_done;

  assign cnt_load = ((state == FETCH) && bus.run) ||
                    ((state == MEM) && (op_q == OP_LOAD));

  mem_wait_counter #(.WIDTH(CNT_W)) u_wait (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (WAIT_INIT),
    .done     (cnt_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= FETCH;
      op_q      <= '0;
      f3_q      <= '0;
      taken_q   <= 1'b0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      case (state)
        FETCH:      if (bus.run) state <= FETCH_WAIT;
        FETCH_WAIT: if (cnt_done) state <= DECODE;
        DECODE: begin
          op_q <= bus.opcode;
          f3_q <= bus.funct3;
          if (is_legal_opcode(bus.opcode)) begin
            state <= EXECUTE;
          end else begin
            state     <= TRAP;
            illegal_q <= 1'b1;
          end
        end
        EXECUTE: begin
          taken_q <= (op_q == OP_BRANCH) && bus.branch_taken;
          state   <= ((op_q == OP_LOAD) || (op_q == OP_STORE)) ? MEM : WRITE_BACK;
        end
        MEM:        state <= (op_q == OP_LOAD) ? MEM_WAIT : WRITE_BACK;
        MEM_WAIT:   if (cnt_done) state <= WRITE_BACK;
        WRITE_BACK: begin
          retired_q <= retired_q + 1'b1;
          state     <= FETCH;
        end
        TRAP:       state <= TRAP;
        default:    state <= FETCH;
      endcase
    end
  end

  logic       imem_en_c, ir_load_c, rf_rd_en_c, alu_en_c;
  logic       dmem_addr_load_c, dmem_wren_c, rf_wren_c, pc_load_c;
  logic [2:0] dmem_funct3_c;
  wd_sel_t    rf_wd_sel_c;
  pc_sel_t    pc_sel_c;

  always_comb begin
    imem_en_c        = 1'b0;
    ir_load_c        = 1'b0;
    rf_rd_en_c       = 1'b0;
    alu_en_c         = 1'b0;
    dmem_addr_load_c = 1'b0;
    dmem_wren_c      = 1'b0;
    dmem_funct3_c    = '0;
    rf_wren_c        = 1'b0;
    rf_wd_sel_c      = WD_ALU;
    pc_load_c        = 1'b0;
    pc_sel_c         = PC_PLUS4;
    case (state)
      // run is combinational here, so reset must gate it explicitly.
      FETCH:      imem_en_c  = bus.run & ~reset;
      FETCH_WAIT: ir_load_c  = cnt_done;
      DECODE:     rf_rd_en_c = 1'b1;
      EXECUTE:    alu_en_c   = 1'b1;
      MEM: begin
        dmem_addr_load_c = 1'b1;
        dmem_wren_c      = (op_q == OP_STORE);
        dmem_funct3_c    = f3_q;
      end
      MEM_WAIT:   dmem_funct3_c = f3_q;
      WRITE_BACK: begin
        pc_load_c = 1'b1;
        rf_wren_c = !((op_q == OP_STORE) || (op_q == OP_BRANCH) || (op_q == OP_FENCE));
        case (op_q)
          OP_LOAD:          rf_wd_sel_c = WD_MEM;
          OP_JAL, OP_JALR:  rf_wd_sel_c = WD_PC4;
          OP_LUI:           rf_wd_sel_c = WD_IMM;
          default:          rf_wd_sel_c = WD_ALU;
        endcase
        case (op_q)
          OP_JAL:    pc_sel_c = PC_JAL;
          OP_JALR:   pc_sel_c = PC_JALR;
          OP_BRANCH: pc_sel_c = taken_q ? PC_BRANCH : PC_PLUS4;
          default:   pc_sel_c = PC_PLUS4;
        endcase
      end
      default: ;
    endcase
  end

  assign bus.imem_en        = imem_en_c;
  assign bus.ir_load        = ir_load_c;
  assign bus.rf_rd_en       = rf_rd_en_c;
  assign bus.alu_en         = alu_en_c;
  assign bus.dmem_addr_load = dmem_addr_load_c;
  assign bus.dmem_wren      = dmem_wren_c;
  assign bus.dmem_funct3    = dmem_funct3_c;
  assign bus.rf_wren        = rf_wren_c;
  assign bus.rf_wd_sel      = rf_wd_sel_c;
  assign bus.pc_load        = pc_load_c;
  assign bus.pc_sel         = pc_sel_c;
  assign bus.illegal_instr  = illegal_q;
  assign bus.retired_count  = retired_q;
endmodule

// File: tb/tb_core_control_fsm.sv
// Bench for core_control_fsm: one instance at MEM_LATENCY=1, one at 3.
// Table of per-instruction outcomes, hand sequences for trap/reset and
// run deassertion, and random instruction streams against a cycle model.
module tb_core_control_fsm;
  typedef struct packed {
    logic       imem_en, ir_load, rf_rd_en, alu_en, dmem_addr_load, dmem_wren;
    logic [2:0] dmem_funct3;
    logic       rf_wren;
    logic [1:0] rf_wd_sel;
    logic       pc_load;
    logic [1:0] pc_sel;
    logic       illegal;
  } outs_t;

  typedef struct {
    bit         l3;
    logic [6:0] op;
    logic [2:0] f3;
    logic       tk;
    int         len;
    logic       wren;
    logic [1:0] wd;
    logic [1:0] ps;
    int         st_pulses;
  } vec_t;

  localparam logic [6:0] LEGAL [10] = '{7'b0110111, 7'b0010111, 7'b1101111,
    7'b1100111, 7'b1100011, 7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b0001111};

  logic clk, reset, run_d, bt_d, dsel;
  logic [6:0] op_d;
  logic [2:0] f3_d;
  int checks, errors, mret;
  outs_t o1, o3, obs;
  logic [31:0] ret_obs;
  vec_t vt [14];

  core_control_fsm_if #(.RETIRE_W(32)) if1 ();
  core_control_fsm_if #(.RETIRE_W(32)) if3 ();

  assign if1.run = run_d & ~dsel;
  assign if3.run = run_d & dsel;
  assign if1.opcode = op_d;  assign if3.opcode = op_d;
  assign if1.funct3 = f3_d;  assign if3.funct3 = f3_d;
  assign if1.branch_taken = bt_d;  assign if3.branch_taken = bt_d;

  core_control_fsm #(.MEM_LATENCY(1), .RETIRE_W(32)) dut1 (.clk(clk), .reset(reset), .bus(if1));
  core_control_fsm #(.MEM_LATENCY(3), .RETIRE_W(32)) dut3 (.clk(clk), .reset(reset), .bus(if3));

  assign o1 = {if1.imem_en, if1.ir_load, if1.rf_rd_en, if1.alu_en, if1.dmem_addr_load,
               if1.dmem_wren, if1.dmem_funct3, if1.rf_wren, if1.rf_wd_sel, if1.pc_load,
               if1.pc_sel, if1.illegal_instr};
  assign o3 = {if3.imem_en, if3.ir_load, if3.rf_rd_en, if3.alu_en, if3.dmem_addr_load,
               if3.dmem_wren, if3.dmem_funct3, if3.rf_wren, if3.rf_wd_sel, if3.pc_load,
               if3.pc_sel, if3.illegal_instr};
  assign obs = dsel ? o3 : o1;
  assign ret_obs = dsel ? if3.retired_count : if1.retired_count;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_legal(input logic [6:0] op);
    foreach (LEGAL[i]) if (LEGAL[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int instr_len(input int L, input logic [6:0] op);
    if (op == 7'b0100011) return 5 + L;
    if (op == 7'b0000011) return 5 + 2 * L;
    return 4 + L;
  endfunction

  // Expected outputs at cycle k of an instruction, counting its FETCH as 0.
  function automatic outs_t model_out(input int k, input int L, input logic [6:0] op,
                                      input logic [2:0] f3, input logic tk);
    outs_t o = '0;
    int wb = instr_len(L, op) - 1;
    if (k == 0) o.imem_en = 1'b1;
    else if (k <= L) o.ir_load = (k == L);
    else if (k == L + 1) o.rf_rd_en = 1'b1;
    else if (!is_legal(op)) o.illegal = 1'b1;
    else if (k == L + 2) o.alu_en = 1'b1;
    else if (k == wb) begin
      o.pc_load = 1'b1;
      o.rf_wren = !(op == 7'b0100011 || op == 7'b1100011 || op == 7'b0001111);
      if (op == 7'b0000011) o.rf_wd_sel = 2'd1;
      else if (op == 7'b1101111 || op == 7'b1100111) o.rf_wd_sel = 2'd2;
      else if (op == 7'b0110111) o.rf_wd_sel = 2'd3;
      if (op == 7'b1101111) o.pc_sel = 2'd1;
      else if (op == 7'b1100111) o.pc_sel = 2'd2;
      else if (op == 7'b1100011 && tk) o.pc_sel = 2'd3;
    end else begin
      o.dmem_funct3 = f3;
      if (k == L + 3) begin
        o.dmem_addr_load = 1'b1;
        o.dmem_wren = (op == 7'b0100011);
      end
    end
    return o;
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    run_d = 1'b1;
    reset = 1'b1;
    #1;
    chk("reset_outputs", obs, '0);
    chk("reset_retired", ret_obs, 0);
    @(negedge clk);
    chk("reset_outputs_hold", obs, '0);
    @(posedge clk); #1;
    reset = 1'b0;
    run_d = 1'b0;
    mret = 0;
  endtask

  // Inputs outside DECODE/EXECUTE are scrambled to prove they are latched.
  task automatic run_instr(input int L, input logic [6:0] op, input logic [2:0] f3,
                           input logic tk, input int drop_at, input int idle);
    int len = instr_len(L, op);
    run_d = 1'b1;
    for (int k = 0; k < len; k++) begin
      if (k == drop_at) run_d = 1'b0;
      op_d = (k == L + 1) ? op : 7'($urandom);
      f3_d = (k == L + 1) ? f3 : 3'($urandom);
      bt_d = (k == L + 2) ? tk : 1'($urandom);
      @(negedge clk);
      chk($sformatf("cycle op=%b k=%0d L=%0d", op, k, L), obs, model_out(k, L, op, f3, tk));
      @(posedge clk); #1;
    end
    mret++;
    chk("retired", ret_obs, mret);
    if (!run_d) begin
      for (int i = 0; i < idle; i++) begin
        @(negedge clk);
        chk("idle_no_fetch", obs, '0);
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int wr = 0;
    bit found = 1'b0;
    outs_t o;
    op_d = v.op; f3_d = v.f3; bt_d = v.tk; run_d = 1'b1;
    for (int k = 0; k < 30 && !found; k++) begin
      @(negedge clk);
      o = obs;
      if (o.dmem_wren) begin
        wr++;
        chk($sformatf("v%0d_store_f3", idx), o.dmem_funct3, v.f3);
      end
      if (o.pc_load) begin
        found = 1'b1;
        chk($sformatf("v%0d_len", idx), k + 1, v.len);
        chk($sformatf("v%0d_rf_wren", idx), o.rf_wren, v.wren);
        chk($sformatf("v%0d_rf_wd_sel", idx), o.rf_wd_sel, v.wd);
        chk($sformatf("v%0d_pc_sel", idx), o.pc_sel, v.ps);
      end
      @(posedge clk); #1;
    end
    chk($sformatf("v%0d_wb_seen", idx), found, 1);
    chk($sformatf("v%0d_wren_pulses", idx), wr, v.st_pulses);
    mret++;
    chk($sformatf("v%0d_retired", idx), ret_obs, mret);
  endtask

  initial begin
    bit seen;
    int L, len, drop;
    logic [6:0] op;
    checks = 0; errors = 0; mret = 0;
    reset = 1'b0; run_d = 1'b0; op_d = '0; f3_d = '0; bt_d = 1'b0; dsel = 1'b0;

    vt[0]  = '{0, 7'b0010011, 3'd0, 1'b0, 5,  1'b1, 2'd0, 2'd0, 0}; // addi
    vt[1]  = '{0, 7'b0110111, 3'd0, 1'b0, 5,  1'b1, 2'd3, 2'd0, 0}; // lui
    vt[2]  = '{0, 7'b0010111, 3'd0, 1'b0, 5,  1'b1, 2'd0, 2'd0, 0}; // auipc
    vt[3]  = '{0, 7'b1101111, 3'd0, 1'b0, 5,  1'b1, 2'd2, 2'd1, 0}; // jal
    vt[4]  = '{0, 7'b1100111, 3'd0, 1'b0, 5,  1'b1, 2'd2, 2'd2, 0}; // jalr
    vt[5]  = '{0, 7'b1100011, 3'd0, 1'b1, 5,  1'b0, 2'd0, 2'd3, 0}; // beq taken
    vt[6]  = '{0, 7'b1100011, 3'd0, 1'b0, 5,  1'b0, 2'd0, 2'd0, 0}; // beq not taken
    vt[7]  = '{0, 7'b0000011, 3'd2, 1'b0, 7,  1'b1, 2'd1, 2'd0, 0}; // lw
    vt[8]  = '{0, 7'b0100011, 3'd0, 1'b0, 6,  1'b0, 2'd0, 2'd0, 1}; // sb
    vt[9]  = '{0, 7'b0110011, 3'd0, 1'b0, 5,  1'b1, 2'd0, 2'd0, 0}; // add
    vt[10] = '{0, 7'b0001111, 3'd0, 1'b0, 5,  1'b0, 2'd0, 2'd0, 0}; // fence
    vt[11] = '{1, 7'b0010011, 3'd0, 1'b0, 7,  1'b1, 2'd0, 2'd0, 0}; // addi, L=3
    vt[12] = '{1, 7'b0000011, 3'd4, 1'b0, 11, 1'b1, 2'd1, 2'd0, 0}; // lbu, L=3
    vt[13] = '{1, 7'b0100011, 3'd2, 1'b0, 8,  1'b0, 2'd0, 2'd0, 1}; // sw, L=3

    do_reset();
    for (int i = 0; i < 11; i++) run_vec(vt[i], i);

    // SYSTEM opcode traps; the flag sticks and nothing retires until reset.
    op_d = 7'b1110011; run_d = 1'b1; seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (obs.illegal) seen = 1'b1;
      @(posedge clk); #1;
    end
    chk("trap_entered", seen, 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("trap_no_pc_load", obs.pc_load, 0);
      chk("trap_sticky", obs.illegal, 1);
      @(posedge clk); #1;
    end
    chk("trap_retired_frozen", ret_obs, mret);
    reset = 1'b1;
    #1;
    chk("reset_clears_illegal", obs.illegal, 0);
    chk("reset_clears_retired", ret_obs, 0);
    chk("reset_mid_trap_outputs", obs, '0);
    @(posedge clk); #1;
    reset = 1'b0; mret = 0;
    #1;
    chk("restart_fetch", obs.imem_en, 1);
    run_d = 1'b0;

    dsel = 1'b1;
    do_reset();
    for (int i = 11; i < 14; i++) run_vec(vt[i], i);
    // Drop run during EXECUTE (cycle L+2): write-back still happens, then idle.
    run_instr(3, 7'b0010011, 3'd0, 1'b0, 5, 5);
    run_instr(3, 7'b0000011, 3'd1, 1'b0, -1, 0);

    for (int d = 0; d < 2; d++) begin
      dsel = d[0];
      L = d ? 3 : 1;
      do_reset();
      for (int n = 0; n < 40; n++) begin
        op = LEGAL[$urandom_range(0, 9)];
        len = instr_len(L, op);
        drop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, len - 1)) : -1;
        run_instr(L, op, 3'($urandom), 1'($urandom), drop, int'($urandom_range(1, 3)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/core_control_fsm.md
Name: core_control_fsm

Overview:
Multi-cycle control sequencer for the RV32I core. It steps each instruction through fetch, decode/register read, execute, memory and write-back, and drives the enables and selects for the PC, instruction register, register file, ALU and the shared memory block. It takes the decoder's opcode/funct3 and the ALU branch compare, and flags illegal instructions.

Parameters:
MEM_LATENCY, 1, memory read latency in cycles (legal 1..4); sets the length of the FETCH_WAIT and MEM_WAIT states
RETIRE_W, 32, width of the retired-instruction counter

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
run  input  1  1 = fetch new instructions; 0 = stop at the next instruction boundary
opcode  input  7  decoder opcode field
funct3  input  3  decoder funct3 field
branch_taken  input  1  ALU compare result; valid in EXECUTE
imem_en  output  1  instruction read strobe
ir_load  output  1  load current_instruction from imem_data_out
rf_rd_en  output  1  register-file read (rs1/rs2 operand latch)
alu_en  output  1  ALU operand/result latch
dmem_addr_load  output  1  latch data address (rs1 + imm)
dmem_wren  output  1  data memory write strobe
dmem_funct3  output  3  access size/sign to memory
rf_wren  output  1  register-file write
rf_wd_sel  output  2  write-back source: 0 ALU, 1 MEM, 2 PC+4, 3 IMM
pc_load  output  1  PC update strobe
pc_sel  output  2  next PC: 0 PC+4, 1 JAL, 2 JALR, 3 BRANCH
illegal_instr  output  1  sticky illegal-opcode flag
retired_count  output  RETIRE_W  instructions completed

Behaviour:
- States (3-bit, registered): FETCH=0, FETCH_WAIT=1, DECODE=2, EXECUTE=3, MEM=4, MEM_WAIT=5, WRITE_BACK=6, TRAP=7.
- Outputs are combinational from the state and the latched op_q, f3_q and taken_q. All strobes are 0 outside their listed states.
- Reset (async): state=FETCH, op_q=0, f3_q=0, taken_q=0, wait counter=0, illegal_instr=0, retired_count=0. All outputs are 0 while reset is high.
- FETCH: if run=1, imem_en=1 and go to FETCH_WAIT with the wait counter loaded to MEM_LATENCY-1. If run=0, hold with all outputs 0.
- FETCH_WAIT: decrement the counter. When it is 0, assert ir_load and go to DECODE.
- DECODE: rf_rd_en=1; latch opcode into op_q and funct3 into f3_q.
  - Legal opcodes: 0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011, 0001111.
  - FENCE (0001111) executes as a NOP.
  - Any other opcode (including SYSTEM 1110011) goes to TRAP; all others go to EXECUTE.
- EXECUTE: alu_en=1; taken_q <= branch_taken when op_q=1100011, else 0. LOAD/STORE go to MEM; everything else goes to WRITE_BACK.
- MEM: dmem_addr_load=1; dmem_funct3=f3_q (held through MEM_WAIT).
  - STORE: dmem_wren=1 for exactly this one cycle, then WRITE_BACK.
  - LOAD: dmem_wren=0, go to MEM_WAIT with the counter at MEM_LATENCY-1.
- MEM_WAIT: count down. At 0, go to WRITE_BACK.
- WRITE_BACK: pc_load=1; retired_count increments (wraps modulo 2^RETIRE_W); next state FETCH.
  - rf_wren=1 except for STORE, BRANCH and FENCE.
  - rf_wd_sel: LOAD→1; JAL/JALR→2; LUI→3; others→0.
  - pc_sel: JAL→1; JALR→2; BRANCH→3 if taken_q else 0; others→0.
- TRAP: illegal_instr=1, all strobes 0, no PC update. Leaves only on reset.
- run deasserted mid-instruction: the instruction completes through WRITE_BACK, then the block holds in FETCH.
- Reset mid-instruction: abandon immediately. No partial rf_wren/dmem_wren after reset is released; restart at FETCH.
- Latency at MEM_LATENCY=L: ALU/jump/branch ops 4+L cycles; store 5+L; load 5+2L.

Decomposition:
- Shared package core_pkg: the state enum, opcode localparams, and rf_wd_sel/pc_sel encodings. These are reused by the decoder and top.
- Optional sub-module mem_wait_counter: loadable down-counter with done flag, instantiated once and shared by FETCH_WAIT and MEM_WAIT.

Test Plan:
- addi, opcode 0010011, run=1, L=1 → ir_load in cycle 2; WRITE_BACK in cycle 5 with rf_wren=1, rf_wd_sel=0, pc_sel=0, pc_load=1; retired_count 0→1.
- lw, opcode 0000011, funct3 010 → dmem_addr_load for 1 cycle, dmem_funct3=010, dmem_wren never 1, one MEM_WAIT cycle; WRITE_BACK rf_wd_sel=1 at cycle 7.
- sw, opcode 0100011, funct3 000 → dmem_wren=1 for exactly one cycle with dmem_funct3=000; WRITE_BACK rf_wren=0, pc_sel=0; total 6 cycles.
- beq with branch_taken=1 → pc_sel=3, rf_wren=0. Repeat with branch_taken=0 → pc_sel=0. jal → pc_sel=1, rf_wd_sel=2.
- opcode 1110011 → TRAP, illegal_instr=1; 20 cycles with no pc_load or retire. Assert reset mid-TRAP → state FETCH, illegal_instr=0, retired_count=0.
- L=3: FETCH_WAIT lasts exactly 3 cycles. Drop run during EXECUTE → WRITE_BACK still occurs, then FETCH holds with imem_en=0 until run returns to 1.
